// File: rtl/piso_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : piso_bit_feeder
// Purpose  : Double-buffered parallel-in/serial-out feeder for the 1010 detector
// Revision : 1.0
// ============================================================================
module piso_bit_feeder #(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             a_out,
   output logic             bit_valid,
   output logic             busy
);
   localparam int                 c_CNT_W   = $clog2(WIDTH);
   localparam int                 c_OUT_IDX = MSB_FIRST ? WIDTH-1 : 0;
   localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH-1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_shift;
   logic [WIDTH-1:0]   r_hold;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_hold_full;
   logic               w_xfer;
   logic [WIDTH-1:0]   w_shifted;

   assign w_xfer = data_valid && !r_hold_full;

   // Vacated positions fill with IDLE_BIT, so a fully drained shifter
   // already presents the idle level on a_out.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_shifted = {r_shift[WIDTH-2:0], IDLE_BIT};
      end else begin : g_lsb_first
         assign w_shifted = {IDLE_BIT, r_shift[WIDTH-1:1]};
      end
   endgenerate

   assign a_out      = r_shift[c_OUT_IDX];
   assign bit_valid  = (r_state == SHIFT);
   assign busy       = (r_state == SHIFT) || r_hold_full;
   assign data_ready = !r_hold_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_shift     <= {WIDTH{IDLE_BIT}};
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_shift <= data_in;
                  r_cnt   <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (r_cnt != c_LAST) begin
                  r_shift <= w_shifted;
                  r_cnt   <= r_cnt + c_CNT_W'(1);
                  if (w_xfer) begin
                     r_hold      <= data_in;
                     r_hold_full <= 1'b1;
                  end
               end else if (r_hold_full) begin
                  // Held word takes over on the same edge: no idle bit between words.
                  r_shift     <= r_hold;
                  r_hold_full <= 1'b0;
                  r_cnt       <= '0;
               end else if (w_xfer) begin
                  r_shift <= data_in;
                  r_cnt   <= '0;
               end else begin
                  r_shift <= w_shifted;
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire
